// File: rtl/pipeline_pkg.sv
// Shared pipeline types and helpers for the front-end stage registers.
package pipeline_pkg;

  localparam int unsigned DEF_INSTR_WIDTH = 32;
  localparam int unsigned DEF_DATA_WIDTH  = 64;
  localparam int unsigned DEF_LANES       = 1;
  localparam int unsigned DEF_CNT_WIDTH   = 16;

  // Fetch packet at the default geometry; parametrised stages build the same layout locally.
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0]                     pc;
    logic [DEF_LANES-1:0][DEF_INSTR_WIDTH-1:0]     instr;
    logic [DEF_LANES-1:0]                          mask;
  } ifid_pkt_t;

  // Number of set bits in a 2-bit kill vector (0, 1 or 2).
  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {v[1] & v[0], v[1] ^ v[0]};
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry skid buffer (main + skid) with valid/ready, flush and accept-without-store.
// in_ready depends only on local state, so there is no combinational path from out_ready.
module pipe_skid_buf #(
  parameter type T = logic [7:0]
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       flush_i,
  input  logic       in_valid_i,
  input  logic       in_drop_i,
  input  T           in_data_i,
  output logic       in_ready_o,
  output logic       out_valid_o,
  output T           out_data_o,
  input  logic       out_ready_i,
  output logic [1:0] kill_c_o
);

  logic m_valid_q, m_valid_d;
  logic s_valid_q, s_valid_d;
  T     m_data_q,  m_data_d;
  T     s_data_q,  s_data_d;

  logic accept;
  logic consume;
  logic store;

  assign accept  = in_valid_i & ~s_valid_q;
  assign consume = m_valid_q & out_ready_i;
  assign store   = accept & ~in_drop_i;

  // Next-state: flush wins, then refill main from skid, else load or spill into skid.
  always_comb begin
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    m_data_d  = m_data_q;
    s_data_d  = s_data_q;
    kill_c_o  = 2'b00;
    if (flush_i) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
      kill_c_o  = {s_valid_q, m_valid_q & ~out_ready_i};
    end else if (consume || !m_valid_q) begin
      if (s_valid_q) begin
        m_valid_d = 1'b1;
        m_data_d  = s_data_q;
        s_valid_d = 1'b0;
      end else begin
        m_valid_d = store;
        if (store) begin
          m_data_d = in_data_i;
        end
      end
    end else if (store) begin
      s_valid_d = 1'b1;
      s_data_d  = in_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_data_q  <= '0;
      s_data_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      m_data_q  <= m_data_d;
      s_data_q  <= s_data_d;
    end
  end

  assign in_ready_o  = ~s_valid_q;
  assign out_valid_o = m_valid_q;
  assign out_data_o  = m_data_q;

endmodule

// File: rtl/ifid_skid_stage.sv
// IF->ID stage register: fetch packet through a 2-entry skid buffer, plus a saturating
// count of packets killed by branch flush.
module ifid_skid_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned LANES       = DEF_LANES,
  parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_pc,
  input  logic [LANES*INSTR_WIDTH-1:0] in_instr,
  input  logic [LANES-1:0]             in_mask,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_pc,
  output logic [LANES*INSTR_WIDTH-1:0] out_instr,
  output logic [LANES-1:0]             out_mask,
  output logic [CNT_WIDTH-1:0]         flush_drops
);

  localparam int unsigned SUM_W = CNT_WIDTH + 1;

  // Same layout as ifid_pkt_t, sized by this instance's parameters.
  typedef struct packed {
    logic [DATA_WIDTH-1:0]             pc;
    logic [LANES-1:0][INSTR_WIDTH-1:0] instr;
    logic [LANES-1:0]                  mask;
  } pkt_t;

  pkt_t in_pkt;
  pkt_t out_pkt;
  logic [1:0] kill_c;

  logic [CNT_WIDTH-1:0] drops_q, drops_d;
  logic [SUM_W-1:0]     drop_sum;

  always_comb begin
    in_pkt       = '0;
    in_pkt.pc    = in_pc;
    in_pkt.instr = in_instr;
    in_pkt.mask  = in_mask;
  end

  // Empty-mask packets complete the handshake but never occupy an entry.
  pipe_skid_buf #(
    .T (pkt_t)
  ) u_buf (
    .clk_i       (clk),
    .rst_ni      (reset),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_drop_i   (in_mask == '0),
    .in_data_i   (in_pkt),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_pkt),
    .out_ready_i (out_ready),
    .kill_c_o    (kill_c)
  );

  assign out_pc    = out_pkt.pc;
  assign out_instr = out_pkt.instr;
  assign out_mask  = out_pkt.mask;

  // Saturating drop counter; carry-out of the widened sum means overflow.
  assign drop_sum = {1'b0, drops_q} + SUM_W'(popcount2(kill_c));

  always_comb begin
    drops_d = drops_q;
    if (flush) begin
      drops_d = drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drops_q <= '0;
    end else begin
      drops_q <= drops_d;
    end
  end

  assign flush_drops = drops_q;

endmodule
